// File: rtl/fs_seq_pkg.sv
// Shared types and defaults for the frame-sync sequencer.
// Used by fs_sequencer, fs_seq_timer and fs_sequencer_if.
package fs_seq_pkg;

  localparam int unsigned NSLOT_DEFAULT     = 4;
  localparam int unsigned TO_CYCLES_DEFAULT = 255;
  localparam int unsigned FRAME_CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SLOT  = 2'd2,
    ST_XMIT  = 2'd3
  } fs_seq_state_e;

  // Width of the slot index: never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fs_sequencer_if.sv
// Bundle of the sequencer's handshake and status signals.
// master: the sequencer side; slave: the shifter/sender/host side.
interface fs_sequencer_if
  import fs_seq_pkg::*;
#(
  parameter int unsigned IDX_W = 2
);

  logic                   fs;
  logic                   ack;
  logic                   senack;
  logic                   cclear;
  logic [IDX_W-1:0]       slot_idx;
  logic                   slot_valid;
  logic                   dt;
  logic                   busy;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   err;

  modport master (
    input  fs, ack, senack,
    output cclear, slot_idx, slot_valid, dt, busy, frame_cnt, err
  );

  modport slave (
    output fs, ack, senack,
    input  cclear, slot_idx, slot_valid, dt, busy, frame_cnt, err
  );

endinterface

// File: rtl/fs_seq_timer.sv
// Watchdog for fs_sequencer: counts cycles spent waiting for a handshake
// and flags expiry when the wait reaches TO_CYCLES cycles.
module fs_seq_timer
  import fs_seq_pkg::*;
#(
  parameter int unsigned TO_CYCLES = TO_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_i,      // FSM is in a state awaiting a handshake
  input  logic progress_i,  // the awaited handshake arrived this cycle
  output logic expire_o
);

  localparam int unsigned CNT_W = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A handshake on the expiry edge wins, so progress masks expiry.
  assign expire_o = wait_i && !progress_i && (cnt_q == CNT_LAST);

  // Next count: restart on any progress, on leaving a wait state, or on expiry.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!wait_i || progress_i || expire_o) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fs_sequencer.sv
// Frame-sync sequencer: on fs, strobes a counter clear, walks NSLOT bit
// slots paced by ack, then requests transmission until senack.
// Optional watchdog compiled in with `define FS_SEQ_TIMEOUT_EN.
module fs_sequencer
  import fs_seq_pkg::*;
#(
  parameter  int unsigned NSLOT     = NSLOT_DEFAULT,
  parameter  int unsigned TO_CYCLES = TO_CYCLES_DEFAULT,
  localparam int unsigned IDX_W     = idx_width(NSLOT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fs,
  input  logic                   ack,
  input  logic                   senack,
  output logic                   cclear,
  output logic [IDX_W-1:0]       slot_idx,
  output logic                   slot_valid,
  output logic                   dt,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLOT - 1);

  // Elaboration-time guard on parameter ranges.
  if (NSLOT < 2 || NSLOT > 256) begin : g_nslot_chk
    $error("fs_sequencer: NSLOT must be in 2..256");
  end
  if (TO_CYCLES < 1) begin : g_to_chk
    $error("fs_sequencer: TO_CYCLES must be at least 1");
  end

  fs_seq_state_e          state_q;
  logic                   cclear_q;
  logic                   slot_valid_q;
  logic [IDX_W-1:0]       slot_idx_q;
  logic                   dt_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

`ifdef FS_SEQ_TIMEOUT_EN
  logic err_q;
  logic waiting;
  logic progress;
  logic timeout;

  assign waiting  = (state_q == ST_SLOT) || (state_q == ST_XMIT);
  assign progress = ((state_q == ST_SLOT) && ack) || ((state_q == ST_XMIT) && senack);

  fs_seq_timer #(
    .TO_CYCLES (TO_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .wait_i     (waiting),
    .progress_i (progress),
    .expire_o   (timeout)
  );

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cclear_q     <= 1'b0;
      slot_valid_q <= 1'b0;
      slot_idx_q   <= '0;
      dt_q         <= 1'b0;
      frame_cnt_q  <= '0;
`ifdef FS_SEQ_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
    end else begin
      cclear_q <= 1'b0;
`ifdef FS_SEQ_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (fs) begin
            state_q  <= ST_CLEAR;
            cclear_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state_q      <= ST_SLOT;
          slot_valid_q <= 1'b1;
          slot_idx_q   <= '0;
        end
        ST_SLOT: begin
          if (ack) begin
            if (slot_idx_q != LAST_IDX) begin
              slot_idx_q <= slot_idx_q + IDX_W'(1);
            end else begin
              state_q      <= ST_XMIT;
              slot_valid_q <= 1'b0;
              slot_idx_q   <= '0;
              dt_q         <= 1'b1;
            end
          end
`ifdef FS_SEQ_TIMEOUT_EN
          else if (timeout) begin
            state_q      <= ST_IDLE;
            slot_valid_q <= 1'b0;
            slot_idx_q   <= '0;
            err_q        <= 1'b1;
          end
`endif
        end
        ST_XMIT: begin
          if (senack) begin
            state_q     <= ST_IDLE;
            dt_q        <= 1'b0;
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
          end
`ifdef FS_SEQ_TIMEOUT_EN
          else if (timeout) begin
            state_q <= ST_IDLE;
            dt_q    <= 1'b0;
            err_q   <= 1'b1;
          end
`endif
        end
        default: begin
          state_q      <= ST_IDLE;
          slot_valid_q <= 1'b0;
          slot_idx_q   <= '0;
          dt_q         <= 1'b0;
        end
      endcase
    end
  end

  assign cclear     = cclear_q;
  assign slot_valid = slot_valid_q;
  assign slot_idx   = slot_idx_q;
  assign dt         = dt_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fs_sequencer.sv
// Directed self-checking bench for fs_sequencer (NSLOT=4, TO_CYCLES=10).
module tb_fs_sequencer;
  import fs_seq_pkg::*;

  localparam int unsigned NSLOT  = 4;
  localparam int unsigned TO_CYC = 10;
  localparam int unsigned IDX_W  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fs_sequencer_if #(.IDX_W(IDX_W)) bus ();

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fs_sequencer #(
    .NSLOT     (NSLOT),
    .TO_CYCLES (TO_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fs         (bus.fs),
    .ack        (bus.ack),
    .senack     (bus.senack),
    .cclear     (bus.cclear),
    .slot_idx   (bus.slot_idx),
    .slot_valid (bus.slot_valid),
    .dt         (bus.dt),
    .busy       (bus.busy),
    .frame_cnt  (bus.frame_cnt),
    .err        (bus.err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic [7:0] fc);
    check({tag, ".busy"},       32'(bus.busy),       32'd0);
    check({tag, ".cclear"},     32'(bus.cclear),     32'd0);
    check({tag, ".slot_valid"}, 32'(bus.slot_valid), 32'd0);
    check({tag, ".slot_idx"},   32'(bus.slot_idx),   32'd0);
    check({tag, ".dt"},         32'(bus.dt),         32'd0);
    check({tag, ".err"},        32'(bus.err),        32'd0);
    check({tag, ".frame_cnt"},  32'(bus.frame_cnt),  32'(fc));
  endtask

  // Pulse fs with ack/senack held high and let the frame complete (7 edges).
  task automatic run_frame();
    bus.fs = 1'b1;
    tick();
    bus.fs = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    bus.fs     = 1'b0;
    bus.ack    = 1'b0;
    bus.senack = 1'b0;
    #1 reset = 1'b0;

    // Reset state, with fs held high during reset: nothing may start.
    bus.fs = 1'b1;
    repeat (3) tick();
    check_quiet("reset", 8'd0);

    // Basic frame: fs pulse, ack and senack held high.
    bus.ack    = 1'b1;
    bus.senack = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    tick();
    bus.fs = 1'b0;
    check("f1.cclear", 32'(bus.cclear), 32'd1);
    check("f1.clr_valid", 32'(bus.slot_valid), 32'd0);
    check("f1.busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("f1.slot%0d.idx", i), 32'(bus.slot_idx), 32'(i));
      check($sformatf("f1.slot%0d.valid", i), 32'(bus.slot_valid), 32'd1);
      check($sformatf("f1.slot%0d.cclear", i), 32'(bus.cclear), 32'd0);
    end
    tick();
    check("f1.dt", 32'(bus.dt), 32'd1);
    check("f1.xmit_idx", 32'(bus.slot_idx), 32'd0);
    check("f1.xmit_valid", 32'(bus.slot_valid), 32'd0);
    tick();
    check_quiet("f1.end", 8'd1);

    // ack withheld for 5 cycles at slot 2.
    bus.ack    = 1'b0;
    bus.senack = 1'b0;
    bus.fs     = 1'b1;
    tick();
    bus.fs = 1'b0;
    check("f2.cclear", 32'(bus.cclear), 32'd1);
    tick();
    check("f2.slot0", 32'(bus.slot_idx), 32'd0);
    bus.ack = 1'b1;
    repeat (2) tick();
    check("f2.slot2", 32'(bus.slot_idx), 32'd2);
    bus.ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("f2.hold%0d.idx", i), 32'(bus.slot_idx), 32'd2);
      check($sformatf("f2.hold%0d.valid", i), 32'(bus.slot_valid), 32'd1);
    end
    bus.ack = 1'b1;
    tick();
    check("f2.slot3", 32'(bus.slot_idx), 32'd3);
    bus.ack = 1'b0;
    tick();
    check("f2.slot3_hold", 32'(bus.slot_idx), 32'd3);
    bus.ack = 1'b1;
    tick();
    check("f2.dt", 32'(bus.dt), 32'd1);
    bus.ack = 1'b0;
    tick();
    check("f2.dt_hold", 32'(bus.dt), 32'd1);
    bus.senack = 1'b1;
    tick();
    check_quiet("f2.end", 8'd2);

    // fs held high across two frames: one cclear each, restart from IDLE.
    bus.ack    = 1'b1;
    bus.senack = 1'b1;
    bus.fs     = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      tick();
      check($sformatf("f3.t%0d.cclear", t), 32'(bus.cclear), 32'((t == 1) || (t == 8)));
      check($sformatf("f3.t%0d.busy", t), 32'(bus.busy), 32'(!((t == 7) || (t == 14))));
    end
    bus.fs = 1'b0;
    check("f3.frame_cnt", 32'(bus.frame_cnt), 32'd4);

    // Asynchronous reset in slot 1.
    bus.fs = 1'b1;
    tick();
    bus.fs = 1'b0;
    repeat (2) tick();
    check("f4.slot1", 32'(bus.slot_idx), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_quiet("f4.reset", 8'd0);
    @(negedge clk);
    reset = 1'b1;
    run_frame();
    check_quiet("f4.after", 8'd1);

    // XMIT stall without senack.
    bus.senack = 1'b0;
    bus.fs     = 1'b1;
    tick();
    bus.fs = 1'b0;
    repeat (5) tick();
    check("f5.dt", 32'(bus.dt), 32'd1);
`ifdef FS_SEQ_TIMEOUT_EN
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("f5.wait%0d.dt", i), 32'(bus.dt), 32'd1);
      check($sformatf("f5.wait%0d.err", i), 32'(bus.err), 32'd0);
    end
    tick();
    check("f5.err", 32'(bus.err), 32'd1);
    check("f5.err_busy", 32'(bus.busy), 32'd0);
    check("f5.err_dt", 32'(bus.dt), 32'd0);
    check("f5.err_fc", 32'(bus.frame_cnt), 32'd1);
    tick();
    check_quiet("f5.err_gone", 8'd1);

    // senack on the same edge as the timeout wins.
    bus.fs = 1'b1;
    tick();
    bus.fs = 1'b0;
    repeat (5) tick();
    repeat (9) tick();
    check("f6.dt", 32'(bus.dt), 32'd1);
    bus.senack = 1'b1;
    tick();
    check_quiet("f6.end", 8'd2);
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("f5.wait%0d.dt", i), 32'(bus.dt), 32'd1);
      check($sformatf("f5.wait%0d.err", i), 32'(bus.err), 32'd0);
    end
    bus.senack = 1'b1;
    tick();
    check_quiet("f5.end", 8'd2);
`endif

    // 256 frames wrap frame_cnt back to 0.
    bus.ack    = 1'b1;
    bus.senack = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int f = 1; f <= 256; f++) begin
      run_frame();
      if (f == 255) begin
        check("wrap.255", 32'(bus.frame_cnt), 32'd255);
      end
    end
    check_quiet("wrap.0", 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fs_sequencer.md
FS_SEQUENCER -- requirements
Module: fs_sequencer

Interface
REQ-001 SHALL have parameter NSLOT, default 4, giving bit slots per frame (legal range 2..256).
REQ-002 SHALL have parameter TO_CYCLES, default 255, giving the ack/senack watchdog limit in clocks (used only with FS_SEQ_TIMEOUT_EN).
REQ-003 SHALL derive localparam IDX_W = max(1, clog2(NSLOT)).
REQ-004 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port `fs`, input, 1 bit: frame-sync start request.
REQ-007 SHALL have port `ack`, input, 1 bit: slot acknowledge from the bit shifter.
REQ-008 SHALL have port `senack`, input, 1 bit: sender acknowledge of `dt`.
REQ-009 SHALL have port `cclear`, output, 1 bit: counter-clear strobe.
REQ-010 SHALL have port `slot_idx`, output, IDX_W bits: current bit-slot index.
REQ-011 SHALL have port `slot_valid`, output, 1 bit: `slot_idx` is live.
REQ-012 SHALL have port `dt`, output, 1 bit: data-transmit request.
REQ-013 SHALL have port `busy`, output, 1 bit: the FSM is not in IDLE.
REQ-014 SHALL have port `frame_cnt`, output, 8 bits: count of completed frames.
REQ-015 SHALL have port `err`, output, 1 bit: watchdog timeout pulse.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, CLEAR, SLOT, XMIT; every output SHALL be registered or decoded from state, with no combinational input-to-output path.
REQ-017 SHALL leave IDLE for CLEAR on the clock edge where `fs`=1; `fs` SHALL be ignored in every other state, including while held high.
REQ-018 SHALL hold `cclear`=1 for exactly one cycle in CLEAR, load slot index 0 and go to SLOT.
REQ-019 SHALL assert `slot_valid`=1 in SLOT; on an edge with `ack`=1 it SHALL increment the index if index < NSLOT-1, else go to XMIT.
REQ-020 SHALL hold the index and stay in SLOT while `ack`=0; with `ack` held high each slot SHALL last exactly 1 cycle.
REQ-021 SHALL assert `dt`=1 in XMIT until an edge with `senack`=1; that edge SHALL go to IDLE and increment `frame_cnt` modulo 256 (255 wraps to 0).
REQ-022 SHALL ignore `ack` outside SLOT and `senack` outside XMIT.
REQ-023 SHALL drive `slot_idx` to 0 whenever `slot_valid`=0.
REQ-024 SHALL give minimum frame latency of NSLOT+3 cycles, from the `fs` edge to return to IDLE.

Reset
REQ-025 SHALL force the FSM to IDLE immediately on `reset`=0, asynchronously and at any point mid-frame.
REQ-026 SHALL hold all outputs at 0 during reset, including `frame_cnt`=0 and `slot_idx`=0.
REQ-027 SHALL keep `fs` ignored while `reset`=0; the first frame SHALL start on the first edge after release that sees `fs`=1.

Configuration
REQ-028 SHALL use macro FS_SEQ_TIMEOUT_EN to compile the watchdog in or out.
REQ-029 SHALL, with the macro defined, count cycles spent in SLOT awaiting `ack` or in XMIT awaiting `senack`, restarting the count on each slot advance or state entry.
REQ-030 SHALL, with the macro defined, pulse `err`=1 for one cycle when the count reaches TO_CYCLES, go to IDLE and leave `frame_cnt` unchanged.
REQ-031 SHALL, with the macro defined, let `ack`/`senack` win when it arrives on the same edge as the timeout.
REQ-032 SHALL, without the macro, tie `err` to 0 and instantiate no timer logic.

Structure
REQ-033 SHALL place in shared package fs_seq_pkg: the state enum typedef, NSLOT_DEFAULT=4, TO_CYCLES_DEFAULT=255 and FRAME_CNT_W=8.
REQ-034 SHALL implement the watchdog as sub-module fs_seq_timer, instantiated only under FS_SEQ_TIMEOUT_EN.

Verification
REQ-035 SHALL cover: NSLOT=4, `fs` pulse, `ack`=1 and `senack`=1 held -> `cclear` in cycle 1, `slot_idx` 0,1,2,3 in cycles 2-5, `dt` in cycle 6, IDLE in cycle 7, `frame_cnt`=1.
REQ-036 SHALL cover: `ack` withheld 5 cycles at slot 2 -> `slot_idx` holds 2 and `slot_valid`=1 throughout, then advances to 3 one edge after `ack`.
REQ-037 SHALL cover: `fs` held high for a whole frame -> exactly one `cclear` per frame, next frame starts on the first edge back in IDLE.
REQ-038 SHALL cover: `reset`=0 asserted at slot 1 -> all outputs 0 without waiting for a clock edge, `frame_cnt`=0.
REQ-039 SHALL cover: 256 completed frames -> `frame_cnt` wraps to 0.
REQ-040 SHALL cover: with FS_SEQ_TIMEOUT_EN, TO_CYCLES=10 and no `senack` -> `err` pulses once 10 cycles into XMIT, then IDLE with `frame_cnt` unchanged.
